// File: rtl/wishbone_pkg.sv
// Shared types and default widths for the Wishbone slave RAM.
// The FSM state enum is also exported on the top-level dbg_state port.
package wishbone_pkg;

  localparam int WB_ADR_WIDTH = 8;
  localparam int WB_DAT_WIDTH = 32;
  localparam int WB_CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wishbone_slave_ram_mem.sv
// Byte-enabled single-port storage: combinational read, synchronous write.
// The caller keeps adr inside 0..MEM_WORDS-1 whenever we is asserted or rdat is used.
module wishbone_slave_ram_mem
  import wishbone_pkg::*;
#(
  parameter int AW        = WB_ADR_WIDTH,
  parameter int DAT_WIDTH = WB_DAT_WIDTH,
  parameter int SEL_WIDTH = DAT_WIDTH / 8,
  parameter int MEM_WORDS = 2 ** AW
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AW-1:0]        adr,
  input  logic [DAT_WIDTH-1:0] wdat,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [DAT_WIDTH-1:0] rdat
);

  logic [DAT_WIDTH-1:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < SEL_WIDTH; i++) begin
        if (sel[i]) mem_q[adr][8*i +: 8] <= wdat[8*i +: 8];
      end
    end
  end

  assign rdat = mem_q[adr];

endmodule

// File: rtl/wishbone_slave_ram.sv
// Classic (non-pipelined) Wishbone slave in front of a byte-enabled RAM.
// Optional macro WB_SLAVE_ERR_EN adds an err output for out-of-range addresses.
module wishbone_slave_ram
  import wishbone_pkg::*;
#(
  parameter int ADR_WIDTH   = WB_ADR_WIDTH,
  parameter int DAT_WIDTH   = WB_DAT_WIDTH,
  parameter int SEL_WIDTH   = DAT_WIDTH / 8,
  parameter int MEM_WORDS   = 2 ** ADR_WIDTH,
  parameter int WAIT_STATES = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADR_WIDTH-1:0] adr,
  input  logic [DAT_WIDTH-1:0] datwr,
  input  logic                 we,
  input  logic [SEL_WIDTH-1:0] sel,
  input  logic                 stb,
  input  logic                 cyc,
  output logic [DAT_WIDTH-1:0] datrd,
  output logic                 ack,
`ifdef WB_SLAVE_ERR_EN
  output logic                 err,
`endif
  output wb_state_e            dbg_state
);

  localparam int MEM_AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [WB_CNT_WIDTH-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? WB_CNT_WIDTH'(WAIT_STATES - 1) : '0;
  localparam logic [ADR_WIDTH:0] MEM_LIMIT = MEM_WORDS[ADR_WIDTH:0];

  // Handshake: the master requests a transfer while cyc & stb are high; the
  // transfer completes in the single cycle where ack (or err) is high.
  logic req;
  assign req = cyc & stb;

  wb_state_e                state_q, state_d;
  logic [WB_CNT_WIDTH-1:0]  cnt_q,   cnt_d;
  logic [ADR_WIDTH-1:0]     adr_q,   adr_d;
  logic                     we_q,    we_d;
  logic [SEL_WIDTH-1:0]     sel_q,   sel_d;
  logic [DAT_WIDTH-1:0]     dat_q,   dat_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    adr_d   = adr_q;
    we_d    = we_q;
    sel_d   = sel_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (req) begin
          adr_d = adr;
          we_d  = we;
          sel_d = sel;
          dat_d = datwr;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = ACK;
          end
        end
      end
      WAIT: begin
        // A master that drops its request mid-wait abandons the transfer.
        if (!req)              state_d = IDLE;
        else if (cnt_q == '0)  state_d = ACK;
        else                   cnt_d   = cnt_q - 1'b1;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      adr_q   <= adr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      dat_q   <= dat_d;
    end
  end

  // rst gates the completion cycle so a reset landing on ACK neither acks nor writes.
  logic ack_cyc;
  logic in_range;
  logic mem_we;
  logic [DAT_WIDTH-1:0] mem_rdat;

  assign ack_cyc  = (state_q == ACK) && !rst;
  assign in_range = {1'b0, adr_q} < MEM_LIMIT;
  assign mem_we   = ack_cyc && we_q && in_range;
  assign datrd    = (ack_cyc && in_range) ? mem_rdat : '0;

`ifdef WB_SLAVE_ERR_EN
  assign ack = ack_cyc && in_range;
  assign err = ack_cyc && !in_range;
`else
  assign ack = ack_cyc;
`endif

  assign dbg_state = state_q;

  wishbone_slave_ram_mem #(
    .AW        (MEM_AW),
    .DAT_WIDTH (DAT_WIDTH),
    .SEL_WIDTH (SEL_WIDTH),
    .MEM_WORDS (MEM_WORDS)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .adr  (adr_q[MEM_AW-1:0]),
    .wdat (dat_q),
    .sel  (sel_q),
    .rdat (mem_rdat)
  );

endmodule

// File: tb/tb_wishbone_slave_ram.sv
// Bench for wishbone_slave_ram: three instances (0 wait states, 3 wait states,
// 16-word memory) driven by directed steps plus random transfers.
module tb_wishbone_slave_ram;
  import wishbone_pkg::*;

`ifdef WB_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [7:0]  adr_a   [3];
  logic [31:0] datwr_a [3];
  logic        we_a    [3];
  logic [3:0]  sel_a   [3];
  logic        stb_a   [3];
  logic        cyc_a   [3];
  logic [31:0] datrd_a [3];
  logic        ack_a   [3];
  logic        err_a   [3];
  wb_state_e   st_a    [3];

  int ws_of    [3] = '{0, 3, 0};
  int words_of [3] = '{256, 256, 16};

  wishbone_slave_ram #(.WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .adr(adr_a[0]), .datwr(datwr_a[0]), .we(we_a[0]),
    .sel(sel_a[0]), .stb(stb_a[0]), .cyc(cyc_a[0]), .datrd(datrd_a[0]), .ack(ack_a[0]),
`ifdef WB_SLAVE_ERR_EN
    .err(err_a[0]),
`endif
    .dbg_state(st_a[0]));

  wishbone_slave_ram #(.WAIT_STATES(3)) u_dut1 (
    .clk(clk), .rst(rst), .adr(adr_a[1]), .datwr(datwr_a[1]), .we(we_a[1]),
    .sel(sel_a[1]), .stb(stb_a[1]), .cyc(cyc_a[1]), .datrd(datrd_a[1]), .ack(ack_a[1]),
`ifdef WB_SLAVE_ERR_EN
    .err(err_a[1]),
`endif
    .dbg_state(st_a[1]));

  wishbone_slave_ram #(.MEM_WORDS(16), .WAIT_STATES(0)) u_dut2 (
    .clk(clk), .rst(rst), .adr(adr_a[2]), .datwr(datwr_a[2]), .we(we_a[2]),
    .sel(sel_a[2]), .stb(stb_a[2]), .cyc(cyc_a[2]), .datrd(datrd_a[2]), .ack(ack_a[2]),
`ifdef WB_SLAVE_ERR_EN
    .err(err_a[2]),
`endif
    .dbg_state(st_a[2]));

`ifndef WB_SLAVE_ERR_EN
  assign err_a[0] = 1'b0;
  assign err_a[1] = 1'b0;
  assign err_a[2] = 1'b0;
`endif

  // reference model and scoreboard
  logic [31:0] mdl [3][256];
  logic [31:0] exp_q [$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic bit exp_err(input int k, input logic [7:0] a);
    return ERR_EN && (int'(a) >= words_of[k]);
  endfunction

  // driver tasks
  task automatic idle_bus(input int k);
    cyc_a[k] = 1'b0; stb_a[k] = 1'b0; we_a[k] = 1'b0;
    adr_a[k] = '0; datwr_a[k] = '0; sel_a[k] = '0;
  endtask

  task automatic xfer(input int k, input bit w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output logic [31:0] rd, output int lat,
                      output bit got_ack, output bit got_err);
    int n;
    bit done;
    @(posedge clk); #1;
    cyc_a[k] = 1'b1; stb_a[k] = 1'b1; we_a[k] = w;
    adr_a[k] = a; datwr_a[k] = d; sel_a[k] = s;
    n = 0; done = 1'b0; rd = '0; got_ack = 1'b0; got_err = 1'b0;
    while (!done && n < 40) begin
      @(posedge clk); n++;
      @(negedge clk);
      if (ack_a[k] || err_a[k]) begin
        done = 1'b1; rd = datrd_a[k]; got_ack = ack_a[k]; got_err = err_a[k];
      end
    end
    idle_bus(k);
    lat = done ? n : -1;
    @(posedge clk); @(negedge clk);
    check("ack_one_cycle", {62'b0, ack_a[k], err_a[k]}, 64'd0);
  endtask

  task automatic do_write(input int k, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s);
    logic [31:0] rd; int lat; bit ga, ge;
    xfer(k, 1'b1, a, d, s, rd, lat, ga, ge);
    check("wr_latency", lat, ws_of[k] + 1);
    check("wr_ack", ga, !exp_err(k, a));
    check("wr_err", ge, exp_err(k, a));
    if (int'(a) < words_of[k]) mdl[k][a] = merge(mdl[k][a], d, s);
  endtask

  task automatic do_read(input int k, input logic [7:0] a);
    logic [31:0] rd; int lat; bit ga, ge;
    exp_q.push_back((int'(a) < words_of[k]) ? mdl[k][a] : 32'h0);
    xfer(k, 1'b0, a, $urandom, 4'($urandom_range(0, 15)), rd, lat, ga, ge);
    check("rd_latency", lat, ws_of[k] + 1);
    check("rd_err", ge, exp_err(k, a));
    check("rd_data", rd, exp_q.pop_front());
  endtask

  initial begin
    logic [5:0]  pattern;
    int          nacks;
    bit          saw;
    logic [7:0]  a;
    for (int k = 0; k < 3; k++) idle_bus(k);

    // reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check("rst_ack", ack_a[k], 1'b0);
      check("rst_datrd", datrd_a[k], 32'h0);
      check("rst_state", st_a[k], IDLE);
    end
    rst = 1'b0;

    // basic write/read, zero wait states
    do_write(0, 8'h10, 32'hDEADBEEF, 4'hF);
    do_read(0, 8'h10);

    // byte lanes and sel=0
    do_write(0, 8'h05, 32'h11223344, 4'hF);
    do_write(0, 8'h05, 32'hAABBCCDD, 4'h5);
    do_read(0, 8'h05);
    check("byte_lanes", mdl[0][5], 32'h11BB33DD);
    do_write(0, 8'h05, 32'hFFFFFFFF, 4'h0);
    do_read(0, 8'h05);

    // three wait states: latency then abort
    do_write(1, 8'h20, 32'h0BADF00D, 4'hF);
    do_read(1, 8'h20);
    @(posedge clk); #1;
    cyc_a[1] = 1'b1; stb_a[1] = 1'b1; we_a[1] = 1'b1;
    adr_a[1] = 8'h20; datwr_a[1] = 32'h55555555; sel_a[1] = 4'hF;
    @(posedge clk); @(posedge clk); @(negedge clk);
    stb_a[1] = 1'b0;
    saw = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); @(negedge clk);
      if (ack_a[1] || err_a[1]) saw = 1'b1;
    end
    idle_bus(1);
    check("abort_no_ack", saw, 1'b0);
    check("abort_state", st_a[1], IDLE);
    do_read(1, 8'h20);

    // back-to-back reads with stb held
    @(posedge clk); #1;
    cyc_a[0] = 1'b1; stb_a[0] = 1'b1; we_a[0] = 1'b0; adr_a[0] = 8'h10; sel_a[0] = 4'hF;
    pattern = '0; nacks = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); @(negedge clk);
      pattern[5-c] = ack_a[0];
      if (ack_a[0]) begin
        nacks++;
        check("b2b_data", datrd_a[0], mdl[0][8'h10]);
        if (nacks == 3) idle_bus(0);
      end
    end
    idle_bus(0);
    check("b2b_pattern", pattern, 6'b101010);

    // reset during WAIT
    do_write(1, 8'h40, 32'h12345678, 4'hF);
    @(posedge clk); #1;
    cyc_a[1] = 1'b1; stb_a[1] = 1'b1; we_a[1] = 1'b1;
    adr_a[1] = 8'h40; datwr_a[1] = 32'hFEEDFACE; sel_a[1] = 4'hF;
    @(posedge clk); @(negedge clk);
    check("wait_state", st_a[1], WAIT);
    rst = 1'b1; idle_bus(1);
    @(posedge clk); @(negedge clk);
    check("rst_wait_ack", ack_a[1], 1'b0);
    check("rst_wait_datrd", datrd_a[1], 32'h0);
    check("rst_wait_state", st_a[1], IDLE);
    rst = 1'b0;
    do_read(1, 8'h40);

    // reset during ACK
    do_write(0, 8'h30, 32'hA5A5A5A5, 4'hF);
    @(posedge clk); #1;
    cyc_a[0] = 1'b1; stb_a[0] = 1'b1; we_a[0] = 1'b1;
    adr_a[0] = 8'h30; datwr_a[0] = 32'h5A5A5A5A; sel_a[0] = 4'hF;
    @(posedge clk); @(negedge clk);
    check("pre_rst_ack", ack_a[0], 1'b1);
    rst = 1'b1; idle_bus(0);
    #1;
    check("rst_ack_gated", ack_a[0], 1'b0);
    check("rst_ack_datrd", datrd_a[0], 32'h0);
    @(posedge clk); @(negedge clk);
    check("rst_ack_state", st_a[0], IDLE);
    rst = 1'b0;
    do_read(0, 8'h30);

    // small memory: out-of-range access
    for (int i = 0; i < 16; i++) do_write(2, 8'(i), $urandom, 4'hF);
    do_write(2, 8'h20, 32'hCAFEF00D, 4'hF);
    do_read(2, 8'h20);
    do_read(2, 8'h00);

    // random traffic
    for (int i = 0; i < 8; i++) begin
      do_write(0, 8'h80 + 8'(i), $urandom, 4'hF);
      do_write(1, 8'h80 + 8'(i), $urandom, 4'hF);
    end
    for (int i = 0; i < 90; i++) begin
      int k;
      k = i % 3;
      a = (k == 2) ? 8'($urandom_range(0, 31)) : 8'h80 + 8'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) do_write(k, a, $urandom, 4'($urandom_range(0, 15)));
      else                           do_read(k, a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wishbone_slave_ram.md
WISHBONE_SLAVE_RAM -- requirements
Module: wishbone_slave_ram

Interface
REQ-001 SHALL have parameter ADR_WIDTH, default 8: word-address width.
REQ-002 SHALL have parameter DAT_WIDTH, default 32: data width; multiple of 8.
REQ-003 SHALL have parameter SEL_WIDTH, default DAT_WIDTH/8: byte-select width.
REQ-004 SHALL have parameter MEM_WORDS, default 2**ADR_WIDTH: implemented words; 1..2**ADR_WIDTH.
REQ-005 SHALL have parameter WAIT_STATES, default 0: extra cycles inserted before ack; 0..15.
REQ-006 Clock is clk, one clock domain; reset is rst, synchronous, active-high.
REQ-007 clk  input  1  clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous active-high reset.
REQ-009 adr  input  ADR_WIDTH  word address from master.
REQ-010 datwr  input  DAT_WIDTH  write data.
REQ-011 we  input  1  1 = write, 0 = read.
REQ-012 sel  input  SEL_WIDTH  byte lane enables; bit i covers datwr/datrd[8i+7:8i].
REQ-013 stb  input  1  strobe; transfer request.
REQ-014 cyc  input  1  bus cycle valid.
REQ-015 datrd  output  DAT_WIDTH  read data.
REQ-016 ack  output  1  transfer complete, one-cycle pulse.

Function
REQ-017 SHALL implement the slave side of the classic (non-pipelined) Wishbone handshake; request = cyc & stb.
REQ-018 SHALL use FSM states IDLE, WAIT, ACK.
REQ-019 IDLE: on request, latch adr/we/sel/datwr; go WAIT if WAIT_STATES>0 (counter loaded WAIT_STATES-1), else ACK.
REQ-020 WAIT: decrement counter; at 0 go ACK; if request drops, go IDLE (abort).
REQ-021 ACK: ack=1 for exactly one cycle; next state IDLE unconditionally.
REQ-022 Latency: ack asserts WAIT_STATES+1 cycles after the cycle request is first sampled in IDLE.
REQ-023 stb held high after ack SHALL be treated as a new request in IDLE; back-to-back transfers complete every WAIT_STATES+2 cycles.
REQ-024 Write: in the ACK cycle, for each sel bit set, write the latched byte to word adr; unselected bytes unchanged.
REQ-025 Read: datrd SHALL equal stored word at latched adr (all lanes, independent of sel) while ack=1; 0 otherwise.
REQ-026 Aborted transfer SHALL cause no write and no ack.
REQ-027 Request with sel=0 SHALL ack normally and modify nothing.
REQ-028 Address adr >= MEM_WORDS: write ignored, read returns 0, ack normal (unless REQ-033).
REQ-029 Memory contents are not reset; after reset reads of unwritten words are undefined.

Reset
REQ-030 rst SHALL force state IDLE, counter 0, ack=0, datrd=0, latched request cleared, in the same edge.
REQ-031 rst during WAIT or ACK SHALL cancel the transfer: no ack, no write in that cycle.

Configuration
REQ-032 Macro WB_SLAVE_ERR_EN SHALL add output err (1 bit).
REQ-033 With WB_SLAVE_ERR_EN: out-of-range (adr >= MEM_WORDS) transfer SHALL pulse err instead of ack in the ACK cycle, same timing; no write; datrd=0; err reset value 0.
REQ-034 Without WB_SLAVE_ERR_EN: no err port; behaviour per REQ-028.

Structure
REQ-035 Package wishbone_pkg SHALL hold the FSM state enum (IDLE, WAIT, ACK) and default width constants.
REQ-036 Storage SHALL be sub-module wishbone_slave_ram_mem: byte-enabled single-port array, combinational read, synchronous write.

Verification
REQ-037 WAIT_STATES=0: write adr 0x10, datwr 0xDEADBEEF, sel 0xF -> ack one cycle later for 1 cycle; read 0x10 -> datrd 0xDEADBEEF during ack.
REQ-038 Byte lanes: preload 0x11223344 at 0x05, write 0xAABBCCDD sel 0x5 -> read 0x11BB33DD.
REQ-039 WAIT_STATES=3: request at cycle 0 -> ack at cycle 4; drop stb at cycle 2 during write -> no ack, memory unchanged.
REQ-040 stb held through 3 back-to-back reads, WAIT_STATES=0 -> acks at cycles 1, 3, 5; ack never high two consecutive cycles.
REQ-041 rst asserted in WAIT -> next cycle ack=0, datrd=0, state IDLE, no write.
REQ-042 MEM_WORDS=16, WB_SLAVE_ERR_EN set: write adr 0x20 -> err pulse, ack 0, no write; macro unset -> ack pulse, read returns 0.
